// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline. Runs load/store transactions over a
// req/ack data-memory handshake and owns the MEM/WB pipeline register.
module mem_access_stage #(
  parameter int DATA      = 32,
  parameter int REG_WIDTH = 5,
  parameter int ADDR_W    = 32,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [DATA-1:0]      ex_alu_result,
  input  logic [DATA-1:0]      ex_store_data,
  input  logic [REG_WIDTH-1:0] ex_dest_reg,
  input  logic                 ex_mem_read,
  input  logic                 ex_mem_write,
  input  logic                 ex_wb_mux,
  input  logic                 ex_reg_write,
  input  logic                 ex_halt,
  output logic                 mem_stall,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [ADDR_W-1:0]    dmem_addr,
  output logic [DATA-1:0]      dmem_wdata,
  input  logic                 dmem_ack,
  input  logic [DATA-1:0]      dmem_rdata,
  output logic                 wb_valid,
  output logic [DATA-1:0]      write_back_data,
  output logic [DATA-1:0]      memory_data_o,
  output logic [REG_WIDTH-1:0] memory_read,
  output logic                 wb_mux,
  output logic                 wb_reg_write,
  output logic                 halt_detected,
  output logic                 mem_error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [DATA-1:0]      h_alu_q, h_alu_d;
  logic [DATA-1:0]      h_wdata_q, h_wdata_d;
  logic [REG_WIDTH-1:0] h_dest_q, h_dest_d;
  logic                 h_we_q, h_we_d;
  logic                 h_mux_q, h_mux_d;
  logic                 h_rw_q, h_rw_d;

  logic                 wb_valid_q, wb_valid_d;
  logic [DATA-1:0]      wb_data_q, wb_data_d;
  logic [DATA-1:0]      mem_data_q, mem_data_d;
  logic [REG_WIDTH-1:0] dest_q, dest_d;
  logic                 wb_mux_q, wb_mux_d;
  logic                 rw_q, rw_d;
  logic                 halt_q, halt_d;
  logic                 err_q, err_d;

  logic                 is_mem, misaligned, busy, tmo;
  logic [ADDR_W-1:0]    h_addr;

  assign is_mem     = ex_mem_read | ex_mem_write;
  assign misaligned = (ex_alu_result[1:0] != 2'b00);
  assign busy       = (state_q == BUSY);
  // Last BUSY cycle before the counter reaches TIMEOUT and the load/store is abandoned.
  assign tmo        = busy && !dmem_ack && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    h_alu_d    = h_alu_q;
    h_wdata_d  = h_wdata_q;
    h_dest_d   = h_dest_q;
    h_we_d     = h_we_q;
    h_mux_d    = h_mux_q;
    h_rw_d     = h_rw_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    mem_data_d = mem_data_q;
    dest_d     = dest_q;
    wb_mux_d   = wb_mux_q;
    rw_d       = 1'b0;
    halt_d     = halt_q;
    err_d      = err_q;
    mem_stall  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (in_valid) begin
          if (ex_halt || !is_mem || misaligned) begin
            wb_valid_d = 1'b1;
            wb_data_d  = ex_alu_result;
            mem_data_d = '0;
            dest_d     = ex_dest_reg;
            wb_mux_d   = ex_wb_mux;
            rw_d       = ex_reg_write;
            if (ex_halt) begin
              halt_d  = 1'b1;
              state_d = HALTED;
            end else if (is_mem) begin
              rw_d  = 1'b0;
              err_d = 1'b1;
            end
          end else begin
            // Load/store: latch operands, hold EX/MEM, and send a bubble down.
            mem_stall = 1'b1;
            h_alu_d   = ex_alu_result;
            h_wdata_d = ex_store_data;
            h_dest_d  = ex_dest_reg;
            h_we_d    = ex_mem_write;
            h_mux_d   = ex_wb_mux;
            h_rw_d    = ex_reg_write;
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        // Release the stall on timeout too, otherwise the abandoned access is replayed.
        mem_stall = !dmem_ack && !tmo;
        if (dmem_ack || tmo) begin
          wb_valid_d = 1'b1;
          wb_data_d  = h_alu_q;
          dest_d     = h_dest_q;
          wb_mux_d   = h_mux_q;
          cnt_d      = '0;
          state_d    = IDLE;
          if (dmem_ack) begin
            mem_data_d = h_we_q ? '0 : dmem_rdata;
            rw_d       = h_rw_q;
          end else begin
            mem_data_d = '0;
            err_d      = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HALTED: mem_stall = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      mem_data_q <= '0;
      dest_q     <= '0;
      wb_mux_q   <= 1'b0;
      rw_q       <= 1'b0;
      halt_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      mem_data_q <= mem_data_d;
      dest_q     <= dest_d;
      wb_mux_q   <= wb_mux_d;
      rw_q       <= rw_d;
      halt_q     <= halt_d;
      err_q      <= err_d;
    end
  end

  // Holding registers are pure data; their contents only matter while BUSY.
  always_ff @(posedge clock) begin
    h_alu_q   <= h_alu_d;
    h_wdata_q <= h_wdata_d;
    h_dest_q  <= h_dest_d;
    h_we_q    <= h_we_d;
    h_mux_q   <= h_mux_d;
    h_rw_q    <= h_rw_d;
  end

  assign h_addr          = ADDR_W'(h_alu_q);
  assign dmem_req        = busy;
  assign dmem_we         = busy & h_we_q;
  assign dmem_addr       = busy ? {h_addr[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_wdata      = busy ? h_wdata_q : '0;

  assign wb_valid        = wb_valid_q;
  assign write_back_data = wb_data_q;
  assign memory_data_o   = mem_data_q;
  assign memory_read     = dest_q;
  assign wb_mux          = wb_mux_q;
  assign wb_reg_write    = rw_q & wb_valid_q;
  assign halt_detected   = halt_q;
  assign mem_error       = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU, load, store, misaligned, timeout,
// halt and reset scenarios with hand-computed expectations.
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dest_reg;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_wb_mux;
  logic        ex_reg_write;
  logic        ex_halt;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] write_back_data;
  logic [31:0] memory_data_o;
  logic [4:0]  memory_read;
  logic        wb_mux;
  logic        wb_reg_write;
  logic        halt_detected;
  logic        mem_error;

  int n_chk = 0;
  int n_err = 0;
  int nbusy;
  bit done;

  always #5 clock = ~clock;

  mem_access_stage #(.DATA(32), .REG_WIDTH(5), .ADDR_W(32), .TIMEOUT(64)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_dest_reg(ex_dest_reg), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_wb_mux(ex_wb_mux),
    .ex_reg_write(ex_reg_write), .ex_halt(ex_halt), .mem_stall(mem_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .write_back_data(write_back_data),
    .memory_data_o(memory_data_o), .memory_read(memory_read),
    .wb_mux(wb_mux), .wb_reg_write(wb_reg_write),
    .halt_detected(halt_detected), .mem_error(mem_error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic clr_in();
    in_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_dest_reg = '0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_wb_mux = 1'b0;
    ex_reg_write = 1'b0; ex_halt = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  task automatic set_in(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [4:0] dst, input logic rd, input logic wr,
                        input logic mux, input logic rw, input logic hlt);
    in_valid = v; ex_alu_result = alu; ex_store_data = sd; ex_dest_reg = dst;
    ex_mem_read = rd; ex_mem_write = wr; ex_wb_mux = mux;
    ex_reg_write = rw; ex_halt = hlt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    clr_in();
    nxt(); nxt();
    mid();
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_mem_error", 64'(mem_error), 64'd0);
    chk("rst_halt", 64'(halt_detected), 64'd0);
    chk("rst_req", 64'(dmem_req), 64'd0);
    chk("rst_stall", 64'(mem_stall), 64'd0);
    chk("rst_wbdata", 64'(write_back_data), 64'd0);

    // ALU instruction; a stray ack outside BUSY must be ignored
    nxt(); reset_n = 1'b1;
    set_in(1'b1, 32'h10, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    mid();
    chk("alu_stall", 64'(mem_stall), 64'd0);
    chk("alu_req", 64'(dmem_req), 64'd0);
    nxt(); clr_in();
    mid();
    chk("alu_wbdata", 64'(write_back_data), 64'h10);
    chk("alu_dest", 64'(memory_read), 64'd3);
    chk("alu_valid", 64'(wb_valid), 64'd1);
    chk("alu_mux", 64'(wb_mux), 64'd1);
    chk("alu_rw", 64'(wb_reg_write), 64'd1);
    chk("alu_memdata", 64'(memory_data_o), 64'd0);

    // Load from 0x100, ack on the third BUSY cycle
    nxt(); set_in(1'b1, 32'h100, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    mid();
    chk("ld_issue_stall", 64'(mem_stall), 64'd1);
    chk("ld_issue_req", 64'(dmem_req), 64'd0);
    nxt(); mid();
    chk("ld_b1_req", 64'(dmem_req), 64'd1);
    chk("ld_b1_stall", 64'(mem_stall), 64'd1);
    chk("ld_b1_addr", 64'(dmem_addr), 64'h100);
    chk("ld_b1_we", 64'(dmem_we), 64'd0);
    chk("ld_b1_bubble", 64'(wb_valid), 64'd0);
    nxt(); mid();
    chk("ld_b2_stall", 64'(mem_stall), 64'd1);
    chk("ld_b2_addr", 64'(dmem_addr), 64'h100);
    nxt(); dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    mid();
    chk("ld_ack_stall", 64'(mem_stall), 64'd0);
    chk("ld_ack_addr", 64'(dmem_addr), 64'h100);
    nxt(); clr_in();
    mid();
    chk("ld_memdata", 64'(memory_data_o), 64'hDEAD_BEEF);
    chk("ld_valid", 64'(wb_valid), 64'd1);
    chk("ld_dest", 64'(memory_read), 64'd5);
    chk("ld_rw", 64'(wb_reg_write), 64'd1);
    chk("ld_mux", 64'(wb_mux), 64'd0);
    chk("ld_wbdata", 64'(write_back_data), 64'h100);
    chk("ld_req_drop", 64'(dmem_req), 64'd0);

    // Store to 0x104 with immediate ack
    nxt(); set_in(1'b1, 32'h104, 32'h1234_5678, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    mid();
    chk("st_issue_stall", 64'(mem_stall), 64'd1);
    nxt(); dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    mid();
    chk("st_req", 64'(dmem_req), 64'd1);
    chk("st_we", 64'(dmem_we), 64'd1);
    chk("st_wdata", 64'(dmem_wdata), 64'h1234_5678);
    chk("st_addr", 64'(dmem_addr), 64'h104);
    chk("st_stall", 64'(mem_stall), 64'd0);
    nxt(); clr_in();
    mid();
    chk("st_valid", 64'(wb_valid), 64'd1);
    chk("st_rw", 64'(wb_reg_write), 64'd0);
    chk("st_memdata", 64'(memory_data_o), 64'd0);
    chk("st_req_drop", 64'(dmem_req), 64'd0);

    // mem_read and mem_write together behave as a store
    nxt(); set_in(1'b1, 32'h108, 32'hA5A5_A5A5, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    mid();
    nxt(); dmem_ack = 1'b1; dmem_rdata = 32'h0F0F_0F0F;
    mid();
    chk("rw_both_we", 64'(dmem_we), 64'd1);
    chk("rw_both_wdata", 64'(dmem_wdata), 64'hA5A5_A5A5);
    nxt(); clr_in();
    mid();
    chk("rw_both_memdata", 64'(memory_data_o), 64'd0);

    // Misaligned load at 0x102
    nxt(); set_in(1'b1, 32'h102, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    mid();
    chk("mis_req", 64'(dmem_req), 64'd0);
    chk("mis_stall", 64'(mem_stall), 64'd0);
    nxt(); clr_in();
    mid();
    chk("mis_err", 64'(mem_error), 64'd1);
    chk("mis_valid", 64'(wb_valid), 64'd1);
    chk("mis_rw", 64'(wb_reg_write), 64'd0);
    chk("mis_memdata", 64'(memory_data_o), 64'd0);
    chk("mis_req_after", 64'(dmem_req), 64'd0);
    nxt(); mid();
    chk("err_sticky", 64'(mem_error), 64'd1);
    chk("bubble_valid", 64'(wb_valid), 64'd0);

    nxt(); reset_n = 1'b0;
    nxt(); reset_n = 1'b1;
    mid();
    chk("rst_err_clear", 64'(mem_error), 64'd0);

    // Load never acked: times out after 64 BUSY cycles, then an ALU op completes
    nxt(); set_in(1'b1, 32'h200, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    nbusy = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      nxt();
      if (dmem_req) nbusy++;
      else done = 1'b1;
    end
    set_in(1'b1, 32'h44, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    mid();
    chk("tmo_busy_cycles", 64'(nbusy), 64'd64);
    chk("tmo_valid", 64'(wb_valid), 64'd1);
    chk("tmo_err", 64'(mem_error), 64'd1);
    chk("tmo_rw", 64'(wb_reg_write), 64'd0);
    chk("tmo_memdata", 64'(memory_data_o), 64'd0);
    chk("tmo_stall", 64'(mem_stall), 64'd0);
    nxt(); clr_in();
    mid();
    chk("post_tmo_wbdata", 64'(write_back_data), 64'h44);
    chk("post_tmo_dest", 64'(memory_read), 64'd7);
    chk("post_tmo_valid", 64'(wb_valid), 64'd1);
    chk("post_tmo_rw", 64'(wb_reg_write), 64'd1);

    // Halt, then further instructions are frozen out
    nxt(); set_in(1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    mid();
    chk("halt_issue_stall", 64'(mem_stall), 64'd0);
    nxt(); set_in(1'b1, 32'h55, 32'h0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    mid();
    chk("halt_flag", 64'(halt_detected), 64'd1);
    chk("halt_valid", 64'(wb_valid), 64'd1);
    chk("halt_stall", 64'(mem_stall), 64'd1);
    for (int k = 0; k < 3; k++) begin
      nxt(); set_in(1'b1, 32'h400, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      mid();
      chk("halted_valid", 64'(wb_valid), 64'd0);
      chk("halted_stall", 64'(mem_stall), 64'd1);
      chk("halted_req", 64'(dmem_req), 64'd0);
    end

    // Reset out of HALTED, then reset in the middle of a BUSY load
    nxt(); reset_n = 1'b0; clr_in();
    nxt(); reset_n = 1'b1;
    mid();
    chk("unhalt_flag", 64'(halt_detected), 64'd0);
    chk("unhalt_stall", 64'(mem_stall), 64'd0);
    nxt(); set_in(1'b1, 32'h300, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    mid();
    nxt(); mid();
    chk("rb_busy_req", 64'(dmem_req), 64'd1);
    nxt(); reset_n = 1'b0;
    nxt();
    chk("rb_req", 64'(dmem_req), 64'd0);
    chk("rb_addr", 64'(dmem_addr), 64'd0);
    chk("rb_valid", 64'(wb_valid), 64'd0);
    chk("rb_err", 64'(mem_error), 64'd0);
    chk("rb_halt", 64'(halt_detected), 64'd0);
    chk("rb_wbdata", 64'(write_back_data), 64'd0);
    chk("rb_memdata", 64'(memory_data_o), 64'd0);
    chk("rb_dest", 64'(memory_read), 64'd0);
    chk("rb_rw", 64'(wb_reg_write), 64'd0);
    reset_n = 1'b1; clr_in();
    mid();
    chk("rb_stall", 64'(mem_stall), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, sitting between the EX/MEM register and the write-back stage.
- Issues load/store transactions to a variable-latency data memory over a req/ack handshake and stalls upstream while a transaction is outstanding.
- Owns the MEM/WB pipeline register: ALU result, load data, destination register, write-back mux select, reg-write enable, halt flag.

Parameters:
- DATA, 32, datapath width in bits
- REG_WIDTH, 5, register-index width
- ADDR_W, 32, data-memory byte-address width
- TIMEOUT, 64, max BUSY cycles waiting for dmem_ack before error completion

Ports:
- clock  input  1  pipeline clock
- reset_n  input  1  synchronous active-low reset
- in_valid  input  1  EX/MEM slot holds a real instruction
- ex_alu_result  input  DATA  ALU result / memory byte address
- ex_store_data  input  DATA  store data
- ex_dest_reg  input  REG_WIDTH  destination register index
- ex_mem_read  input  1  load
- ex_mem_write  input  1  store
- ex_wb_mux  input  1  1 = write back ALU result, 0 = write back load data
- ex_reg_write  input  1  instruction writes the register file
- ex_halt  input  1  halt instruction
- mem_stall  output  1  hold EX/MEM and all earlier stages this cycle
- dmem_req  output  1  memory request valid
- dmem_we  output  1  1 = write
- dmem_addr  output  ADDR_W  word-aligned byte address
- dmem_wdata  output  DATA  write data
- dmem_ack  input  1  request complete; dmem_rdata valid this cycle
- dmem_rdata  input  DATA  read data
- wb_valid  output  1  MEM/WB slot valid
- write_back_data  output  DATA  registered ALU result
- memory_data_o  output  DATA  registered load data
- memory_read  output  REG_WIDTH  registered destination register
- wb_mux  output  1  registered write-back select
- wb_reg_write  output  1  registered reg-write, forced 0 when wb_valid = 0
- halt_detected  output  1  registered halt, sticky
- mem_error  output  1  sticky: misaligned access or timeout

Behaviour:
- Reset: synchronous, active-low, sampled on the rising edge of clock.
  - All MEM/WB outputs, mem_error, halt_detected, wb_valid and the timeout counter clear to 0.
  - State returns to IDLE. Any outstanding request is abandoned and dmem_req drops the next cycle.
- States: IDLE, BUSY, HALTED.
- IDLE, in_valid = 1, non-memory instruction (mem_read = 0, mem_write = 0):
  - MEM/WB loads the inputs at the next edge; memory_data_o = 0; wb_valid = 1.
  - Latency is 1 cycle. mem_stall = 0.
- IDLE, in_valid = 1, memory instruction, ex_alu_result[1:0] = 0:
  - Operands are captured into holding registers and state goes to BUSY.
  - mem_stall = 1 combinationally in this cycle. MEM/WB loads a bubble: wb_valid = 0, wb_reg_write = 0.
- BUSY:
  - dmem_req = 1. dmem_addr, dmem_we and dmem_wdata are driven from the holding registers and are stable until ack.
  - mem_stall = !dmem_ack.
  - On dmem_ack: MEM/WB loads the held fields, memory_data_o = dmem_rdata (0 for a store), wb_valid = 1, state goes to IDLE.
  - The ack cycle has mem_stall = 0, so the next instruction is presented the following cycle. Minimum load/store latency is 2 cycles.
- Timeout: the counter increments in each BUSY cycle without ack. When the count reaches TIMEOUT, the instruction completes:
  - memory_data_o = 0, wb_reg_write = 0, mem_error = 1, state goes to IDLE.
- Misaligned access (memory instruction with ex_alu_result[1:0] != 0):
  - No request is issued. Completes in 1 cycle: wb_valid = 1, wb_reg_write = 0, memory_data_o = 0, mem_error = 1.
- in_valid = 0 in IDLE: MEM/WB loads a bubble.
- Halt: an instruction with ex_halt = 1 completes like a non-memory instruction and sets halt_detected = 1.
  - State goes to HALTED.
  - In HALTED: mem_stall = 1, dmem_req = 0, MEM/WB holds a bubble, and only reset exits.
- mem_read and mem_write both asserted: treated as a store.
- dmem_ack outside BUSY: ignored.
- dmem_req is never asserted in IDLE or HALTED.
- wb_mux passes through unchanged for every valid instruction.

Test Plan:
- ALU instruction: alu_result = 0x0000_0010, dest = 3, wb_mux = 1 -> next cycle write_back_data = 0x10, memory_read = 3, wb_valid = 1, mem_stall = 0.
- Load from 0x100, ack after 3 BUSY cycles with rdata = 0xDEAD_BEEF:
  - mem_stall high for 3 cycles, dmem_addr stable at 0x100.
  - memory_data_o = 0xDEADBEEF the cycle after ack.
- Store to 0x104, data 0x1234_5678, immediate ack -> one dmem_req cycle with dmem_we = 1 and wdata = 0x12345678; wb_reg_write = 0.
- Misaligned load at 0x102 -> no dmem_req, mem_error = 1 next cycle, wb_reg_write = 0.
- Load with ack never asserted -> completes after TIMEOUT (64) cycles with mem_error = 1, then a following ALU instruction completes normally.
- Two scenarios on halt and reset:
  - Halt followed by valid ALU instructions -> halt_detected = 1, mem_stall stays 1, no further wb_valid.
  - Reset pulse mid-BUSY -> all outputs 0 and dmem_req deasserts.
